// File: rtl/inv_share_arb_pkg.sv
// Shared defaults for the inversion-sharing arbiter slice.
// Holds the width helper used to size requester indices.
package inv_share_arb_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;
  localparam int IDW_DEF  = clog2(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker.
// Searches upward from rr_ptr_i, wrapping, and reports one-hot plus index.
module rr_arbiter_core
  import inv_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  rr_ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  int             c;
  logic [IDW-1:0] ci;
  logic           found;

  // first asserted request at or after the pointer, in wrap order
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 0; k < NREQ; k++) begin
      c  = (int'(rr_ptr_i) + k) % NREQ;
      ci = IDW'(c);
      if (en_i && !found && req_i[ci]) begin
        found     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/inv_share_arb.sv
// Shares one registered inversion stage among NREQ requesters.
// The result register doubles as a one-deep valid/ready output slot.
module inv_share_arb
  import inv_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            slot_free;
  logic            arb_en;
  logic [NREQ-1:0] gnt_w;
  logic [IDW-1:0]  gidx;
  logic [DW-1:0]   sel_data;

  // A draining word frees the slot in the same cycle it leaves.
  assign slot_free = ~valid_q | out_ready;
  assign arb_en    = slot_free & rst_n;

  rr_arbiter_core #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (ptr_q),
    .en_i     (arb_en),
    .gnt_o    (gnt_w),
    .idx_o    (gidx)
  );

  // pick the granted requester's word out of the flat bus
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_w[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  // load on grant, empty on drain, otherwise hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (|gnt_w) begin
      valid_d = 1'b1;
      data_d  = ~sel_data;
      id_d    = gidx;
      ptr_d   = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // output slot and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_w;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy      = valid_q & ~out_ready;

endmodule

// File: tb/tb_inv_share_arb.sv
// Bench for inv_share_arb: directed scenarios then random traffic.
// Expected values come from a cycle-level reference of the sharing rules.
module tb_inv_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic               busy;

  inv_share_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_id;
  int          wait_c [NREQ];
  logic [NREQ-1:0] last_gnt;
  bit          saw2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_data  = '0;
    m_id    = 0;
    last_gnt = '0;
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
  endtask

  // one clock cycle: drive, compare with reference, advance reference
  task automatic step(input logic [NREQ-1:0] r,
                      input logic [NREQ*DW-1:0] d,
                      input logic rdy);
    int eg;
    int c;
    logic [NREQ-1:0] egv;
    @(negedge clk);
    req = r;
    req_data = d;
    out_ready = rdy;
    #1;
    eg = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (eg < 0 && r[c]) eg = c;
      end
    end
    egv = '0;
    if (eg >= 0) egv[eg] = 1'b1;
    chk("gnt", 32'(gnt), 32'(egv));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("busy", 32'(busy), 32'(m_valid && !rdy));
    if (out_valid && out_id == 2'd2) saw2 = 1;
    for (int i = 0; i < NREQ; i++) begin
      if (!r[i] || gnt[i]) begin
        wait_c[i] = 0;
      end else if (|gnt) begin
        wait_c[i]++;
        chk("fair", 32'(wait_c[i] < NREQ), 32'd1);
      end
    end
    if (eg >= 0) begin
      m_data  = ~d[eg*DW +: DW];
      m_id    = eg;
      m_valid = 1;
      m_ptr   = (eg + 1) % NREQ;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    last_gnt = gnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] nr;
    n_chk  = 0;
    n_fail = 0;
    saw2   = 0;
    rst_n  = 1'b0;
    req    = '1;
    req_data = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_id", 32'(out_id), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request, first word
    step(4'b0001, 32'h0000_003C, 1'b1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    step(4'b0000, 32'h0, 1'b1);
    chk("t1_data", 32'(out_data), 32'hC3);
    chk("t1_id", 32'(out_id), 32'd0);

    // all requesting: rotating grants at full rate
    do_reset();
    for (int n = 0; n < 6; n++) step(4'b1111, 32'h0, 1'b1);

    // stall holds the word and blocks grants, release grants same cycle
    do_reset();
    step(4'b0001, 32'h0000_00A5, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step(4'b0010, 32'h0, 1'b0);
      chk("t3_hold", 32'(out_data), 32'h5A);
      chk("t3_busy", 32'(busy), 32'd1);
    end
    step(4'b0010, 32'h0, 1'b1);
    chk("t3_gnt", 32'(gnt), 32'h2);
    step(4'b0000, 32'h0, 1'b1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_id", 32'(out_id), 32'd1);

    // pointer wrap from index 3 back to 0
    do_reset();
    step(4'b0100, 32'h0, 1'b1);
    step(4'b1001, 32'h0, 1'b1);
    chk("t4_gnt3", 32'(gnt), 32'h8);
    step(4'b1001, 32'h0, 1'b1);
    chk("t4_gnt0", 32'(gnt), 32'h1);

    // asynchronous reset mid-stream
    do_reset();
    step(4'b1111, 32'h1234_5678, 1'b1);
    step(4'b1111, 32'h9ABC_DEF0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 32'h0, 1'b1);
    chk("t5_first", 32'(gnt), 32'h1);

    // withdrawn request never yields a word
    do_reset();
    step(4'b0001, 32'h0, 1'b0);
    saw2 = 0;
    for (int n = 0; n < 3; n++) step(4'b0100, 32'hFFFF_FFFF, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    for (int n = 0; n < 3; n++) step(4'b0000, 32'h0, 1'b1);
    chk("t6_no_id2", 32'(saw2), 32'd0);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i])
          nr[i] = 1'($urandom_range(0, 1));
        else if (req[i])
          nr[i] = ($urandom_range(0, 9) != 0);
        else
          nr[i] = 1'($urandom_range(0, 1));
      end
      step(nr, $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
